hazard_controller: RTL and testbench
====================================

# hazard_controller

Pipeline sequencing controller for the 16-bit MIPS pipeline. It sits beside the forwarding unit and drives the enable, flush and bubble controls of the PC and the IF/ID, ID/EX and EX/MEM registers. It covers four cases: load-use hazards, taken-branch flushes, data-memory wait states and program halt. It keeps its own shadow copy of the EX/MEM opcode and destination pipeline so that its decisions stay aligned with the real pipeline registers.

## Interface
- OPC_W, 6, opcode width (instruction[15:10])
- REG_W, 3, register-index width
- WAIT_W, 8, memory-wait timeout counter width
- STAT_W, 16, statistics counter width
- Clock  in  1  pipeline clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- Opcode_ID  in  OPC_W  opcode in ID stage
- Src_A_ID, Src_B_ID  in  REG_W  source registers in ID
- Dst_ID  in  REG_W  destination register in ID
- Branch_Taken_EX  in  1  branch in EX resolved taken
- Mem_Req  in  1  MEM stage is accessing data memory
- Mem_Ack  in  1  data memory completes access this cycle
- PC_Enable, IF_ID_Enable, EX_MEM_Enable  out  1  register load enables
- IF_ID_Flush  out  1  load NOP into IF/ID
- ID_EX_Bubble  out  1  load NOP into ID/EX
- Opcode_EX, Opcode_MEM  out  OPC_W  shadow opcodes (feed forwarding unit)
- Halted  out  1  HALT has retired from MEM
- Timeout  out  1  sticky: memory wait exceeded limit
- Stall_Count  out  STAT_W  (only with HAZARD_STATS_EN)

## Operation
- States: RUN, MEM_WAIT, DRAIN, HALTED.
- Shadow pipeline advance (when EX_MEM_Enable=1):
  - Opcode_EX <= (ID_EX_Bubble ? OP_NOP : Opcode_ID); Dst_EX follows the same rule.
  - Opcode_MEM <= Opcode_EX.
- Outputs are combinational from the state, the shadow registers and the current inputs.
- Priority, highest first: memory wait, branch flush, load-use, halt.
- **Memory wait.** In RUN with Mem_Req=1 and Mem_Ack=0:
  - All enables are 0 this cycle and the state goes to MEM_WAIT.
  - MEM_WAIT holds every enable at 0 until Mem_Ack=1. On that cycle all enables are 1 and the state returns to RUN.
- **Branch.** Branch_Taken_EX=1 asserts IF_ID_Flush=1 and ID_EX_Bubble=1, with PC_Enable=1 so the target loads.
- **Load-use.** The condition is Opcode_EX==OP_LD, Dst_EX!=0, and Dst_EX equal to Src_A_ID or Src_B_ID. Response:
  - PC_Enable=0, IF_ID_Enable=0, ID_EX_Bubble=1 for exactly one cycle.
  - The next cycle the LD is in MEM, so the condition clears.
- **Halt.**
  - Opcode_ID==OP_HALT: PC_Enable=0 and IF_ID_Enable=0 from that cycle on, and the state goes to DRAIN. The pipeline keeps advancing.
  - When Opcode_MEM==OP_HALT, the state goes to HALTED: Halted=1 and all enables 0 until reset.
- **Timeout.** The wait counter clears on entry to MEM_WAIT and increments each MEM_WAIT cycle. At 2^WAIT_W−1:
  - Timeout is set and stays set until reset.
  - The state returns to RUN and the access is treated as acknowledged.
- Simultaneous branch and load-use: the branch wins; the bubble already covers the hazard.
- A branch arriving while in MEM_WAIT is honoured on the release cycle.

## Timing
- Reset values:
  - State RUN, shadow registers OP_NOP / 0, counters 0.
  - PC_Enable, IF_ID_Enable and EX_MEM_Enable are 1.
  - IF_ID_Flush, ID_EX_Bubble, Halted and Timeout are 0.
- Hazard detection to control output: 0 cycles (same-cycle combinational).
- Load-use costs 1 bubble; a taken branch costs 2 squashed slots. A memory wait of N cycles freezes the pipeline for N cycles.
- Reset asserted mid-wait or mid-drain returns to RUN immediately, asynchronously.

## Configuration
- HAZARD_STATS_EN:
  - Defined: Stall_Count increments on every cycle with PC_Enable=0 and the state not HALTED, saturating at all-ones.
  - Undefined: the port and counter are absent.

## Structure
- OP_NOP=6'h00, OP_LD=6'h08, OP_ST=6'h09, OP_BEQ=6'h0A and OP_HALT=6'h3F go into the shared definitions file alongside the existing opcode definitions.
- The state encoding (2-bit) also goes into the shared definitions file.
- Sub-module hazard_detect: purely combinational load-use comparator, instantiated once.

## Test plan
- Reset_n=0 → all enables 1, flush/bubble 0, Opcode_EX=Opcode_MEM=6'h00.
- LD r2 then ADD using r2 → exactly one cycle with PC_Enable=0 and ID_EX_Bubble=1, then the pipeline resumes; the same pair with r0 as destination → no stall.
- Branch_Taken_EX=1 for one cycle → IF_ID_Flush=1, ID_EX_Bubble=1, PC_Enable=1; the next cycle Opcode_EX=6'h00.
- Mem_Req=1 with Mem_Ack low for 3 cycles → enables 0 for 3 cycles, all 1 on the ack cycle, state back to RUN.
- Mem_Ack never asserted with WAIT_W=4 → Timeout=1 after 15 MEM_WAIT cycles, stays 1 until reset.
- OP_HALT fetched → PC frozen, Halted=1 two cycles later, enables 0; with HAZARD_STATS_EN, Stall_Count counts the frozen PC cycles before HALTED.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared opcode and state definitions for the 16-bit MIPS pipeline control slice,
// plus the control-bundle type and steering helper used by hazard_controller.
package hazard_controller_pkg;

    localparam logic [5:0] OP_NOP  = 6'h00;
    localparam logic [5:0] OP_ADD  = 6'h01;
    localparam logic [5:0] OP_SUB  = 6'h02;
    localparam logic [5:0] OP_AND  = 6'h03;
    localparam logic [5:0] OP_OR   = 6'h04;
    localparam logic [5:0] OP_LD   = 6'h08;
    localparam logic [5:0] OP_ST   = 6'h09;
    localparam logic [5:0] OP_BEQ  = 6'h0A;
    localparam logic [5:0] OP_HALT = 6'h3F;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_DRAIN    = 2'd2,
        ST_HALTED   = 2'd3
    } hzState_t;

    typedef struct packed {
        logic pcEn;
        logic ifIdEn;
        logic exMemEn;
        logic flush;
        logic bubble;
        logic halted;
    } hzCtrl_t;

    localparam hzCtrl_t CTRL_RUN    = '{pcEn: 1'b1, ifIdEn: 1'b1, exMemEn: 1'b1, flush: 1'b0, bubble: 1'b0, halted: 1'b0};
    localparam hzCtrl_t CTRL_FREEZE = '{pcEn: 1'b0, ifIdEn: 1'b0, exMemEn: 1'b0, flush: 1'b0, bubble: 1'b0, halted: 1'b0};
    localparam hzCtrl_t CTRL_HALT   = '{pcEn: 1'b0, ifIdEn: 1'b0, exMemEn: 1'b0, flush: 1'b0, bubble: 1'b0, halted: 1'b1};

    // Branch beats load-use (its bubble already covers the hazard), load-use beats a fetch hold.
    function automatic hzCtrl_t steerCtrl(input logic branch, input logic loadUse, input logic holdFetch);
        hzCtrl_t c;
        c = CTRL_RUN;
        if (branch) begin
            c.flush  = 1'b1;
            c.bubble = 1'b1;
        end else if (loadUse) begin
            c.pcEn   = 1'b0;
            c.ifIdEn = 1'b0;
            c.bubble = 1'b1;
        end else if (holdFetch) begin
            c.pcEn   = 1'b0;
            c.ifIdEn = 1'b0;
        end
        return c;
    endfunction

endpackage

// File: rtl/hazard_controller_hazard_detect.sv
// Combinational load-use comparator: a load in EX whose destination feeds an ID source.
module hazard_detect
    import hazard_controller_pkg::*;
#(
    parameter int unsigned OPC_W = 6,
    parameter int unsigned REG_W = 3
) (
    input  logic [OPC_W-1:0] opcodeEx,
    input  logic [REG_W-1:0] dstEx,
    input  logic [REG_W-1:0] srcA,
    input  logic [REG_W-1:0] srcB,
    output logic             loadUse
);

    always_comb begin
        loadUse = (opcodeEx == OPC_W'(OP_LD)) && (dstEx != '0) &&
                  ((dstEx == srcA) || (dstEx == srcB));
    end

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencing controller: load-use stalls, branch flushes, memory waits and halt.
// Optional stall statistics port/counter enabled with `define HAZARD_STATS_EN.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int unsigned OPC_W  = 6,
    parameter int unsigned REG_W  = 3,
    parameter int unsigned WAIT_W = 8
`ifdef HAZARD_STATS_EN
    ,
    parameter int unsigned STAT_W = 16
`endif
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic [OPC_W-1:0]  Opcode_ID,
    input  logic [REG_W-1:0]  Src_A_ID,
    input  logic [REG_W-1:0]  Src_B_ID,
    input  logic [REG_W-1:0]  Dst_ID,
    input  logic              Branch_Taken_EX,
    input  logic              Mem_Req,
    input  logic              Mem_Ack,
    output logic              PC_Enable,
    output logic              IF_ID_Enable,
    output logic              EX_MEM_Enable,
    output logic              IF_ID_Flush,
    output logic              ID_EX_Bubble,
    output logic [OPC_W-1:0]  Opcode_EX,
    output logic [OPC_W-1:0]  Opcode_MEM,
    output logic              Halted,
    output logic              Timeout
`ifdef HAZARD_STATS_EN
    ,
    output logic [STAT_W-1:0] Stall_Count
`endif
);

    localparam logic [WAIT_W-1:0] WAIT_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

    hzState_t          state;
    hzState_t          nextState;
    hzCtrl_t           ctrl;
    logic [OPC_W-1:0]  opEx;
    logic [OPC_W-1:0]  opMem;
    logic [REG_W-1:0]  dstEx;
    logic [WAIT_W-1:0] waitCnt;
    logic              timeoutQ;
    logic              loadUse;
    logic              memStall;
    logic              waitExpire;
    logic              waitRelease;
    logic              haltId;
    logic              haltMem;

    hazard_detect #(
        .OPC_W (OPC_W),
        .REG_W (REG_W)
    ) uDetect (
        .opcodeEx (opEx),
        .dstEx    (dstEx),
        .srcA     (Src_A_ID),
        .srcB     (Src_B_ID),
        .loadUse  (loadUse)
    );

    always_comb begin
        memStall    = Mem_Req && !Mem_Ack;
        waitExpire  = !Mem_Ack && (waitCnt == WAIT_LAST);
        waitRelease = Mem_Ack || waitExpire;
        haltId      = (Opcode_ID == OPC_W'(OP_HALT));
        haltMem     = (opMem == OPC_W'(OP_HALT));
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= ST_RUN;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            ST_RUN: begin
                if (memStall) begin
                    nextState = ST_MEM_WAIT;
                end else if (!Branch_Taken_EX && !loadUse && haltId) begin
                    nextState = ST_DRAIN;
                end
            end
            ST_MEM_WAIT: begin
                if (waitRelease) begin
                    nextState = (!Branch_Taken_EX && !loadUse && haltId) ? ST_DRAIN : ST_RUN;
                end
            end
            ST_DRAIN: begin
                // A wait here drops to MEM_WAIT; the frozen HALT in ID re-enters DRAIN on release.
                if (memStall) begin
                    nextState = ST_MEM_WAIT;
                end else if (haltMem) begin
                    nextState = ST_HALTED;
                end else if (Branch_Taken_EX) begin
                    nextState = ST_RUN;
                end
            end
            ST_HALTED: begin
                nextState = ST_HALTED;
            end
        endcase
    end

    always_comb begin
        ctrl = CTRL_RUN;
        unique case (state)
            ST_RUN:      ctrl = memStall ? CTRL_FREEZE : steerCtrl(Branch_Taken_EX, loadUse, haltId);
            ST_MEM_WAIT: ctrl = waitRelease ? steerCtrl(Branch_Taken_EX, loadUse, haltId) : CTRL_FREEZE;
            ST_DRAIN:    ctrl = memStall ? CTRL_FREEZE :
                                haltMem  ? CTRL_HALT   : steerCtrl(Branch_Taken_EX, loadUse, 1'b1);
            ST_HALTED:   ctrl = CTRL_HALT;
        endcase
    end

    assign PC_Enable     = ctrl.pcEn;
    assign IF_ID_Enable  = ctrl.ifIdEn;
    assign EX_MEM_Enable = ctrl.exMemEn;
    assign IF_ID_Flush   = ctrl.flush;
    assign ID_EX_Bubble  = ctrl.bubble;
    assign Halted        = ctrl.halted;
    assign Opcode_EX     = opEx;
    assign Opcode_MEM    = opMem;
    assign Timeout       = timeoutQ;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            opEx  <= OPC_W'(OP_NOP);
            dstEx <= '0;
            opMem <= OPC_W'(OP_NOP);
        end else if (ctrl.exMemEn) begin
            opEx  <= ctrl.bubble ? OPC_W'(OP_NOP) : Opcode_ID;
            dstEx <= ctrl.bubble ? '0 : Dst_ID;
            opMem <= opEx;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            waitCnt  <= '0;
            timeoutQ <= 1'b0;
        end else begin
            if (state != ST_MEM_WAIT && nextState == ST_MEM_WAIT) begin
                waitCnt <= '0;
            end else if (state == ST_MEM_WAIT) begin
                waitCnt <= waitCnt + 1'b1;
            end
            if (state == ST_MEM_WAIT && waitExpire) begin
                timeoutQ <= 1'b1;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    logic [STAT_W-1:0] statCnt;

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            statCnt <= '0;
        end else if (!ctrl.pcEn && state != ST_HALTED && statCnt != '1) begin
            statCnt <= statCnt + 1'b1;
        end
    end

    assign Stall_Count = statCnt;
`endif

endmodule

// File: tb/tb_hazard_controller.sv
// Directed scoreboard bench for hazard_controller (WAIT_W overridden to 4 for the timeout case).
module tb_hazard_controller;

    localparam logic [6:0] V_RUN   = 7'b1110000;
    localparam logic [6:0] V_STALL = 7'b0010100;
    localparam logic [6:0] V_BR    = 7'b1111100;
    localparam logic [6:0] V_FRZ   = 7'b0000000;
    localparam logic [6:0] V_HOLD  = 7'b0010000;
    localparam logic [6:0] V_HALT  = 7'b0000010;
    localparam logic [6:0] V_TMO   = 7'b0000001;

    typedef struct {
        string       tag;
        logic [18:0] vec;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset_n = 1'b0;
    logic [5:0] Opcode_ID = '0;
    logic [2:0] Src_A_ID = '0;
    logic [2:0] Src_B_ID = '0;
    logic [2:0] Dst_ID = '0;
    logic       Branch_Taken_EX = 1'b0;
    logic       Mem_Req = 1'b0;
    logic       Mem_Ack = 1'b0;
    logic       PC_Enable, IF_ID_Enable, EX_MEM_Enable, IF_ID_Flush, ID_EX_Bubble;
    logic [5:0] Opcode_EX, Opcode_MEM;
    logic       Halted, Timeout;
`ifdef HAZARD_STATS_EN
    logic [15:0] Stall_Count;
`endif

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    hazard_controller #(
        .OPC_W  (6),
        .REG_W  (3),
        .WAIT_W (4)
    ) dut (
        .Clock           (Clock),
        .Reset_n         (Reset_n),
        .Opcode_ID       (Opcode_ID),
        .Src_A_ID        (Src_A_ID),
        .Src_B_ID        (Src_B_ID),
        .Dst_ID          (Dst_ID),
        .Branch_Taken_EX (Branch_Taken_EX),
        .Mem_Req         (Mem_Req),
        .Mem_Ack         (Mem_Ack),
        .PC_Enable       (PC_Enable),
        .IF_ID_Enable    (IF_ID_Enable),
        .EX_MEM_Enable   (EX_MEM_Enable),
        .IF_ID_Flush     (IF_ID_Flush),
        .ID_EX_Bubble    (ID_EX_Bubble),
        .Opcode_EX       (Opcode_EX),
        .Opcode_MEM      (Opcode_MEM),
        .Halted          (Halted),
        .Timeout         (Timeout)
`ifdef HAZARD_STATS_EN
        ,
        .Stall_Count     (Stall_Count)
`endif
    );

    always #5 Clock = ~Clock;

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic drive(input logic [5:0] opc, input logic [2:0] sa, input logic [2:0] sbr,
                         input logic [2:0] dst, input logic br, input logic req, input logic ack);
        Opcode_ID       = opc;
        Src_A_ID        = sa;
        Src_B_ID        = sbr;
        Dst_ID          = dst;
        Branch_Taken_EX = br;
        Mem_Req         = req;
        Mem_Ack         = ack;
    endtask

    task automatic expectOut(input string tag, input logic [6:0] ctl, input logic [5:0] ex, input logic [5:0] mem);
        exp_t e;
        e.tag = tag;
        e.vec = {ctl, ex, mem};
        sb.push_back(e);
    endtask

    task automatic checkOut();
        exp_t        e;
        logic [18:0] obs;
        #2;
        e   = sb.pop_front();
        obs = {PC_Enable, IF_ID_Enable, EX_MEM_Enable, IF_ID_Flush, ID_EX_Bubble, Halted, Timeout,
               Opcode_EX, Opcode_MEM};
        checks++;
        assert (obs === e.vec) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.vec);
        end
    endtask

    task automatic step(input string tag, input logic [5:0] opc, input logic [2:0] sa, input logic [2:0] sbr,
                        input logic [2:0] dst, input logic br, input logic req, input logic ack,
                        input logic [6:0] ctl, input logic [5:0] ex, input logic [5:0] mem);
        drive(opc, sa, sbr, dst, br, req, ack);
        expectOut(tag, ctl, ex, mem);
        checkOut();
        @(negedge Clock);
    endtask

    initial begin
        drive(6'h01, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        expectOut("reset", V_RUN, 6'h00, 6'h00);
        checkOut();
        @(negedge Clock);
        Reset_n = 1'b1;

        // load-use on Src_A, then on Src_B, then r0 destination (no stall)
        step("lu_ld",      6'h08, 3'd1, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, V_RUN,   6'h00, 6'h00);
        step("lu_stall_a", 6'h01, 3'd2, 3'd4, 3'd5, 1'b0, 1'b0, 1'b0, V_STALL, 6'h08, 6'h00);
        step("lu_resume",  6'h01, 3'd2, 3'd4, 3'd5, 1'b0, 1'b0, 1'b0, V_RUN,   6'h00, 6'h08);
        step("r0_ld",      6'h08, 3'd1, 3'd3, 3'd0, 1'b0, 1'b0, 1'b0, V_RUN,   6'h01, 6'h00);
        step("r0_use",     6'h01, 3'd0, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, V_RUN,   6'h08, 6'h01);
        step("lu_ld_b",    6'h08, 3'd1, 3'd1, 3'd3, 1'b0, 1'b0, 1'b0, V_RUN,   6'h01, 6'h08);
        step("lu_stall_b", 6'h01, 3'd1, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, V_STALL, 6'h08, 6'h01);
        step("lu_resume_b",6'h01, 3'd1, 3'd3, 3'd2, 1'b0, 1'b0, 1'b0, V_RUN,   6'h00, 6'h08);

        // branch coinciding with a load-use: branch controls win
        step("br_ld",      6'h08, 3'd0, 3'd0, 3'd6, 1'b0, 1'b0, 1'b0, V_RUN,   6'h01, 6'h00);
        step("br_taken",   6'h01, 3'd6, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0, V_BR,    6'h08, 6'h01);
        step("br_after",   6'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, V_RUN,   6'h00, 6'h08);

        // three-cycle memory wait
        step("mw_enter",   6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b0, V_FRZ,   6'h00, 6'h00);
        step("mw_wait1",   6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b0, V_FRZ,   6'h00, 6'h00);
        step("mw_wait2",   6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b0, V_FRZ,   6'h00, 6'h00);
        step("mw_ack",     6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b1, V_RUN,   6'h00, 6'h00);
        step("mw_run",     6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, V_RUN,   6'h01, 6'h00);

        // branch held during a wait is honoured on release
        step("mwb_enter",  6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b0, V_FRZ,   6'h01, 6'h01);
        step("mwb_hold",   6'h01, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0, V_FRZ,   6'h01, 6'h01);
        step("mwb_rel",    6'h01, 3'd1, 3'd2, 3'd3, 1'b1, 1'b1, 1'b1, V_BR,    6'h01, 6'h01);
        step("mwb_after",  6'h00, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, V_RUN,   6'h00, 6'h01);

        // Mem_Ack never comes: 15 MEM_WAIT cycles then forced release and sticky Timeout
        step("tmo_enter",  6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b0, V_FRZ,   6'h00, 6'h00);
        for (int i = 0; i < 14; i++) begin
            step("tmo_wait", 6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b0, V_FRZ, 6'h00, 6'h00);
        end
        step("tmo_expire", 6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b0, V_RUN,           6'h00, 6'h00);
        step("tmo_sticky", 6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b0, V_FRZ | V_TMO,   6'h01, 6'h00);
        step("tmo_ack",    6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b1, 1'b1, V_RUN | V_TMO,   6'h01, 6'h00);
        step("tmo_run",    6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0, V_RUN | V_TMO,   6'h01, 6'h01);

        // HALT fetched: fetch frozen, pipeline drains, Halted two cycles later
        step("halt_id",    6'h3F, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, V_HOLD | V_TMO,  6'h01, 6'h01);
        step("halt_drain", 6'h3F, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, V_HOLD | V_TMO,  6'h3F, 6'h01);
        step("halt_mem",   6'h3F, 3'd0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, V_HALT | V_TMO,  6'h3F, 6'h3F);
        step("halted_br",  6'h01, 3'd1, 3'd2, 3'd3, 1'b1, 1'b0, 1'b0, V_HALT | V_TMO,  6'h3F, 6'h3F);
        drive(6'h01, 3'd1, 3'd2, 3'd3, 1'b0, 1'b0, 1'b0);
        expectOut("halted_hold", V_HALT | V_TMO, 6'h3F, 6'h3F);
        checkOut();
`ifdef HAZARD_STATS_EN
        checks++;
        assert (Stall_Count === 16'd26) else begin
            errors++;
            $error("FAIL stall_count observed=%0d expected=%0d", Stall_Count, 26);
        end
`endif

        // asynchronous reset away from any clock edge
        Reset_n = 1'b0;
        #1;
        expectOut("async_rst", V_RUN, 6'h00, 6'h00);
        checkOut();
`ifdef HAZARD_STATS_EN
        checks++;
        assert (Stall_Count === 16'd0) else begin
            errors++;
            $error("FAIL stall_count_rst observed=%0d expected=%0d", Stall_Count, 0);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
